// File: rtl/fetch_control.sv
// Byte-serial instruction fetch controller: four big-endian byte reads per instruction, then hand the word to the execute unit.
// Optional build macro FETCH_CONTROL_MISALIGN_TRAP_EN: an unaligned PC at the start of a fetch halts instead of fetching.
module fetch_control #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [31:0]           o_mem_addr,
    output logic                  o_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [31:0]           o_inst,
    output logic [31:0]           o_pc,
    input  logic [31:0]           i_exec_mem_addr,
    input  logic                  i_exec_mem_write,
    input  logic [DATA_WIDTH-1:0] i_exec_mem_data,
    output logic [DATA_WIDTH-1:0] o_exec_mem_data,
    input  logic                  i_ready,
    input  logic                  i_pc_change,
    input  logic [31:0]           i_new_pc,
    input  logic                  i_invalid_inst,
    output logic                  o_retire,
    output logic                  o_halted,
    output logic [1:0]            o_state
);

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FETCH;
            k_q     <= 2'd0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        o_mem_addr  = 32'd0;
        o_mem_write = 1'b0;
        o_mem_data  = '0;
        o_inst      = NOP_INST;
        o_retire    = 1'b0;

        case (state_q)
            FETCH: begin
`ifdef FETCH_CONTROL_MISALIGN_TRAP_EN
                if (k_q == 2'd0 && pc_q[1:0] != 2'b00) begin
                    state_d = HALT;
                end else begin
`else
                begin
`endif
                    o_mem_addr = pc_q + {30'd0, k_q};
                    // Byte 0 lands in the most significant lane (big-endian).
                    case (k_q)
                        2'd0:    inst_d[31:24] = i_mem_data[7:0];
                        2'd1:    inst_d[23:16] = i_mem_data[7:0];
                        2'd2:    inst_d[15:8]  = i_mem_data[7:0];
                        default: inst_d[7:0]   = i_mem_data[7:0];
                    endcase
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                o_inst      = inst_q;
                o_mem_addr  = i_exec_mem_addr;
                o_mem_write = i_exec_mem_write;
                o_mem_data  = i_exec_mem_data;
                // An undecodable instruction halts even on its last cycle and never retires.
                if (i_invalid_inst) begin
                    state_d = HALT;
                end else if (i_ready) begin
                    o_retire = 1'b1;
                    pc_d     = i_pc_change ? i_new_pc : pc_q + 32'd4;
                    k_d      = 2'd0;
                    state_d  = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign o_pc            = pc_q;
    assign o_halted        = (state_q == HALT);
    assign o_exec_mem_data = i_mem_data;
    assign o_state         = state_q;

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 i_clk  input  1  sole clock; all state updates on posedge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 o_mem_addr  output  32  byte address to memory port.
REQ-005 o_mem_write  output  1  memory write strobe.
REQ-006 o_mem_data  output  DATA_WIDTH  memory write data.
REQ-007 i_mem_data  input  DATA_WIDTH  memory read data (combinational read).
REQ-008 o_inst  output  32  instruction presented to execute unit.
REQ-009 o_pc  output  32  PC of o_inst.
REQ-010 i_exec_mem_addr / i_exec_mem_write / i_exec_mem_data  input  32/1/DATA_WIDTH  execute-unit memory request.
REQ-011 o_exec_mem_data  output  DATA_WIDTH  read data returned to execute unit.
REQ-012 i_ready  input  1  execute unit in last cycle of current instruction.
REQ-013 i_pc_change / i_new_pc  input  1/32  execute-unit redirect request and target.
REQ-014 i_invalid_inst  input  1  execute unit flags undecodable instruction.
REQ-015 o_retire  output  1  one-cycle pulse per committed instruction.
REQ-016 o_halted  output  1  controller halted.

Function
REQ-017 FSM states SHALL be FETCH, EXEC, HALT.
REQ-018 FETCH SHALL read 4 bytes over 4 consecutive cycles, byte counter k=0..3, o_mem_addr=pc+k (mod 2^32), o_mem_write=0, o_mem_data=0.
REQ-019 Fetch SHALL be big-endian: byte k captured into inst[31-8k -: 8], matching execute-unit load ordering.
REQ-020 During FETCH and HALT, o_inst SHALL be the `NOP encoding from common.svh; execute unit never sees a partial instruction.
REQ-021 After cycle k=3, next state EXEC; o_inst SHALL hold the full captured word for the entire EXEC residency.
REQ-022 In EXEC, memory port SHALL pass i_exec_mem_addr/write/data through combinationally; o_exec_mem_data SHALL equal i_mem_data in all states.
REQ-023 In EXEC with i_ready=0, state, o_pc and o_inst SHALL hold.
REQ-024 In EXEC with i_ready=1 and i_invalid_inst=0: pc <= i_pc_change ? i_new_pc : pc+4 (mod 2^32); o_retire=1 that cycle; next state FETCH, k=0.
REQ-025 In EXEC with i_invalid_inst=1 (regardless of i_ready): next state HALT; pc unchanged; o_retire=0.
REQ-026 HALT SHALL be sticky until i_rst; o_halted=1, o_mem_addr=0, o_mem_write=0, o_mem_data=0.
REQ-027 i_ready, i_pc_change, i_invalid_inst SHALL be ignored in FETCH and HALT.
REQ-028 Minimum per-instruction latency SHALL be 5 cycles (4 fetch + 1 exec).

Reset
REQ-029 On i_rst=1 at posedge: state FETCH, k=0, pc=RESET_PC, captured inst=`NOP, o_halted=0, o_retire=0.
REQ-030 Reset SHALL take precedence over all other inputs, including mid-fetch and mid-EXEC; partial fetch data discarded.
REQ-031 First cycle after reset release SHALL drive o_mem_addr=RESET_PC, o_mem_write=0.

Configuration
REQ-032 Macro FETCH_CONTROL_MISALIGN_TRAP_EN defined: entering FETCH with pc[1:0]!=0 SHALL go to HALT instead, no memory access issued.
REQ-033 Macro undefined: pc[1:0] SHALL be ignored; fetch proceeds byte-wise from the unaligned address.

Verification
REQ-034 Reset, mem[0..3]=00,50,00,93 -> o_mem_addr 0,1,2,3 on cycles 1-4; cycle 5 o_inst=32'h00500093, i_ready=1 gives o_retire=1; next cycle o_pc=4, o_mem_addr=4.
REQ-035 EXEC, i_ready=1, i_pc_change=1, i_new_pc=32'h100 -> next 4 cycles o_mem_addr 100,101,102,103; o_pc=32'h100.
REQ-036 EXEC, i_ready=0 for 3 cycles then 1, execute drives addr 200..203 write=1 -> memory sees exactly those 4 writes; o_pc constant; one o_retire pulse.
REQ-037 EXEC, i_invalid_inst=1 with i_ready=1 -> o_halted=1, o_retire=0, o_inst=`NOP, o_mem_write=0 for 20 cycles; i_rst restores fetch at RESET_PC.
REQ-038 i_new_pc=32'h102: with macro -> HALT, no fetch; without -> fetch addrs 102..105.
REQ-039 i_rst asserted at fetch byte k=2 -> next cycle o_mem_addr=RESET_PC, k=0, o_inst=`NOP.
